// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the two-master data-bus arbiter: FSM encodings,
// master IDs, bus widths and the per-master request bundle.
package dbus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic bus_req_t pick_req(input logic sel, input bus_req_t r0, input bus_req_t r1);
    return sel ? r1 : r0;
  endfunction

endpackage

// File: rtl/dbus_arbiter_rr_arb2.sv
// Combinational two-way picker: a lone requester wins; on a tie the last
// winner keeps the bus while its lock hold is active, otherwise the other one.
module rr_arb2
  import dbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       lock_hold,
  output logic       win,
  output logic       valid
);

  always_comb begin
    valid = |req;
    win   = M_CPU;
    case (req)
      2'b01:   win = M_CPU;
      2'b10:   win = M_AUX;
      2'b11:   win = lock_hold ? rr_last : ~rr_last;
      default: win = M_CPU;
    endcase
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: picks one master per transaction, drives
// registered slave strobes, and returns a done pulse with read data.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_be,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_be,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [BE_W-1:0]   s_be,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  output logic              s_re,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  logic [1:0] state;
  logic       rr_last;
  logic       last_lock;
  logic [3:0] lock_cnt;
  logic [1:0] lat_cnt;

  bus_req_t r0;
  bus_req_t r1;
  bus_req_t sel;
  logic     win;
  logic     win_valid;
  logic     lock_hold;
  logic     other_req;

  assign r0 = {m0_we, m0_lock, m0_addr, m0_be, m0_wdata};
  assign r1 = {m1_we, m1_lock, m1_addr, m1_be, m1_wdata};

  // rr_last always equals the previous owner after the first grant, so the
  // picker can use it as "who holds the lock" on a tie.
  assign lock_hold = last_lock && (lock_cnt < LOCK_MAX);

  rr_arb2 u_pick (
    .req       ({m1_req, m0_req}),
    .rr_last   (rr_last),
    .lock_hold (lock_hold),
    .win       (win),
    .valid     (win_valid)
  );

  assign sel       = pick_req(win, r0, r1);
  assign other_req = (win == M_AUX) ? m0_req : m1_req;

  assign m0_gnt    = (state == ST_ADDR) && (owner == M_CPU);
  assign m1_gnt    = (state == ST_ADDR) && (owner == M_AUX);
  assign m0_done   = (state == ST_RESP) && (owner == M_CPU);
  assign m1_done   = (state == ST_RESP) && (owner == M_AUX);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Lock streak: only grants won against a waiting competitor count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt  <= 4'd0;
      last_lock <= 1'b0;
    end else if (state == ST_IDLE && win_valid) begin
      last_lock <= sel.lock;
      if (win != owner || !sel.lock) begin
        lock_cnt <= 4'd0;
      end else if (other_req && last_lock && lock_cnt < LOCK_MAX) begin
        lock_cnt <= lock_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      owner    <= M_CPU;
      rr_last  <= M_AUX;
      lat_cnt  <= 2'd0;
      s_addr   <= '0;
      s_be     <= '0;
      s_wdata  <= '0;
      s_we     <= 1'b0;
      s_re     <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            s_addr  <= sel.addr;
            s_be    <= sel.be;
            s_wdata <= sel.wdata;
            s_we    <= sel.we;
            s_re    <= ~sel.we;
            owner   <= win;
            rr_last <= win;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          s_we <= 1'b0;
          if (s_re) begin
            lat_cnt <= LAT_LAST;
            state   <= ST_WAIT;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            s_re <= 1'b0;
            if (owner == M_AUX) m1_rdata <= s_rdata;
            else                m0_rdata <= s_rdata;
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: per-master driver queues, a monitor that
// pops expected completions and slave writes, and a final report.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 4;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_lock, m0_we, m0_gnt, m0_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_lock, m1_we, m1_gnt, m1_done;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_we, s_re, owner, busy;
  logic [1:0]  dbg_state;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tb_req_t;

  tb_req_t     q0[$];
  tb_req_t     q1[$];
  // {master, is_read, gnt_gap, gnt_wait, done_lat, rdata}; 0 in gap/wait = not checked
  logic [57:0] exp_q[$];
  logic [67:0] wexp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rc0 = 0, rc1 = 0;
  int prev_gnt = 0, gnt_cyc = 0, act_gap = 0, act_wt = 0, re_run = 0;
  bit have_prev = 0;
  bit pop0, pop1;

  dbus_arbiter #(.RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .owner(owner), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h8) ? 32'h0000_1234 : {16'hA5A5, a[15:0]};
  endfunction

  assign s_rdata = s_re ? slave_data(s_addr) : 32'h0;

  function automatic logic [57:0] mk(input logic m, input logic rd, input int gap,
                                     input int wt, input int lat, input logic [31:0] rdata);
    return {m, rd, 8'(gap), 8'(wt), 8'(lat), rdata};
  endfunction

  function automatic tb_req_t rq(input logic we, input logic lock, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
    return {we, lock, addr, be, wdata};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  // drivers: present queue head, pop when its grant is seen
  initial begin
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_be = 0; m0_wdata = 0;
    forever begin
      @(negedge clk);
      pop0 = 0;
      if (m0_gnt && q0.size() > 0) begin
        q0.delete(0);
        pop0 = 1;
      end
      if (q0.size() > 0) begin
        if (!m0_req || pop0) rc0 = cyc;
        {m0_we, m0_lock, m0_addr, m0_be, m0_wdata} = q0[0];
        m0_req = 1;
      end else begin
        m0_req = 0;
      end
    end
  end

  initial begin
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
    forever begin
      @(negedge clk);
      pop1 = 0;
      if (m1_gnt && q1.size() > 0) begin
        q1.delete(0);
        pop1 = 1;
      end
      if (q1.size() > 0) begin
        if (!m1_req || pop1) rc1 = cyc;
        {m1_we, m1_lock, m1_addr, m1_be, m1_wdata} = q1[0];
        m1_req = 1;
      end else begin
        m1_req = 0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [57:0] e;
    logic [67:0] w;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) re_run = 0;
      else if (s_re) re_run++;
      else if (re_run != 0) begin
        chk("s_re_len", 32'(re_run), 32'(1 + RD_LAT));
        re_run = 0;
      end
      if (s_we || s_re) chk("strobe_excl", 32'(s_we & s_re), 32'h0);
      if (m0_gnt || m1_gnt) begin
        chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'h0);
        chk("gnt_owner", 32'(owner), 32'(m1_gnt));
        act_gap   = have_prev ? cyc - prev_gnt : 0;
        prev_gnt  = cyc;
        have_prev = 1;
        act_wt    = cyc - (m1_gnt ? rc1 : rc0);
        gnt_cyc   = cyc;
      end
      if (s_we) begin
        if (wexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h expected no write", s_addr);
        end else begin
          w = wexp_q.pop_front();
          chk("s_addr", s_addr, w[67:36]);
          chk("s_be", 32'(s_be), 32'(w[35:32]));
          chk("s_wdata", s_wdata, w[31:0]);
        end
      end
      if (m0_done || m1_done) begin
        chk("done_onehot", 32'(m0_done & m1_done), 32'h0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: m0=%0b m1=%0b expected none", m0_done, m1_done);
        end else begin
          e = exp_q.pop_front();
          chk("done_master", 32'(m1_done), 32'(e[57]));
          chk("done_lat", 32'(cyc - gnt_cyc), 32'(e[39:32]));
          if (e[56]) chk("rdata", m1_done ? m1_rdata : m0_rdata, e[31:0]);
          if (e[55:48] != 8'd0) chk("gnt_gap", 32'(act_gap), 32'(e[55:48]));
          if (e[47:40] != 8'd0) chk("gnt_wait", 32'(act_wt), 32'(e[47:40]));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 ||
            wexp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_strobes", 32'({s_we, s_re}), 32'h0);
    chk("rst_pulses", 32'({m0_gnt, m1_gnt, m0_done, m1_done}), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n   = 1;
    have_prev = 0;
  endtask

  // directed sequence
  initial begin
    int n;
    reset_n = 0;
    do_reset();

    // single write from M0
    sync();
    q0.push_back(rq(1'b1, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF));
    wexp_q.push_back({32'h100, 4'hF, 32'hDEADBEEF});
    exp_q.push_back(mk(M_CPU, 1'b0, 0, 1, 1, 32'h0));
    wait_drain(50);
    chk("idle_addr_hold", s_addr, 32'h100);
    chk("idle_wdata_hold", s_wdata, 32'hDEADBEEF);

    // single read from M1
    sync();
    q1.push_back(rq(1'b0, 1'b0, 32'h8, 4'hF, 32'h0));
    exp_q.push_back(mk(M_AUX, 1'b1, 0, 1, 1 + RD_LAT, 32'h1234));
    wait_drain(50);
    repeat (3) @(negedge clk);
    chk("m1_rdata_hold", m1_rdata, 32'h1234);
    chk("m0_rdata_untouched", m0_rdata, 32'h0);
    chk("idle_strobes", 32'({s_we, s_re}), 32'h0);

    // simultaneous reads from reset: M0 first, then strict alternation
    do_reset();
    sync();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rq(1'b0, 1'b0, 32'h200 + 32'(4 * i), 4'hF, 32'h0));
      q1.push_back(rq(1'b0, 1'b0, 32'h300 + 32'(4 * i), 4'hF, 32'h0));
      exp_q.push_back(mk(M_CPU, 1'b1, (i == 0) ? 0 : 3 + RD_LAT, (i == 0) ? 1 : 0,
                         1 + RD_LAT, slave_data(32'h200 + 32'(4 * i))));
      exp_q.push_back(mk(M_AUX, 1'b1, 3 + RD_LAT, (i == 0) ? 4 + RD_LAT : 0,
                         1 + RD_LAT, slave_data(32'h300 + 32'(4 * i))));
    end
    wait_drain(200);

    // lock limit: M0 once, M1 five in a row, M0 forced in, then M1 alone
    sync();
    for (int i = 0; i < 6; i++)
      q1.push_back(rq(1'b1, 1'b1, 32'h400 + 32'(4 * i), 4'hC, 32'h1000_0000 + 32'(i)));
    q0.push_back(rq(1'b1, 1'b0, 32'h500, 4'h3, 32'h2000_0000));
    q0.push_back(rq(1'b1, 1'b0, 32'h504, 4'h3, 32'h2000_0001));
    exp_q.push_back(mk(M_CPU, 1'b0, 0, 1, 1, 32'h0));
    wexp_q.push_back({32'h500, 4'h3, 32'h2000_0000});
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(M_AUX, 1'b0, 3, (i == 0) ? 4 : 0, 1, 32'h0));
      wexp_q.push_back({32'h400 + 32'(4 * i), 4'hC, 32'h1000_0000 + 32'(i)});
    end
    exp_q.push_back(mk(M_CPU, 1'b0, 3, 0, 1, 32'h0));
    wexp_q.push_back({32'h504, 4'h3, 32'h2000_0001});
    exp_q.push_back(mk(M_AUX, 1'b0, 3, 0, 1, 32'h0));
    wexp_q.push_back({32'h414, 4'hC, 32'h1000_0005});
    wait_drain(200);
    chk("lock_final_owner", 32'(owner), 32'h1);

    // back-to-back writes from M0 with req held
    sync();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rq(1'b1, 1'b0, 32'h600 + 32'(4 * i), 4'h5, 32'hCAFE_0000 + 32'(i)));
      wexp_q.push_back({32'h600 + 32'(4 * i), 4'h5, 32'hCAFE_0000 + 32'(i)});
      exp_q.push_back(mk(M_CPU, 1'b0, (i == 0) ? 0 : 3, (i == 0) ? 1 : 0, 1, 32'h0));
    end
    wait_drain(100);
    chk("b2b_final_owner", 32'(owner), 32'h0);

    // reset in the middle of a WAIT: transaction dropped, M0 served first after
    sync();
    q1.push_back(rq(1'b0, 1'b0, 32'h700, 4'hF, 32'h0));
    n = 0;
    while (!m1_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_gnt_seen", 32'(m1_gnt), 32'h1);
    q0.push_back(rq(1'b0, 1'b0, 32'h710, 4'hF, 32'h0));
    @(posedge clk);
    #3;
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("pre_rst_s_re", 32'(s_re), 32'h1);
    reset_n = 0;
    #1;
    chk("rst_wait_s_re", 32'(s_re), 32'h0);
    chk("rst_wait_busy", 32'(busy), 32'h0);
    chk("rst_wait_done", 32'({m0_done, m1_done}), 32'h0);
    q1.push_back(rq(1'b0, 1'b0, 32'h720, 4'hF, 32'h0));
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'({m0_done, m1_done}), 32'h0);
    end
    exp_q.push_back(mk(M_CPU, 1'b1, 0, 0, 1 + RD_LAT, slave_data(32'h710)));
    exp_q.push_back(mk(M_AUX, 1'b1, 3 + RD_LAT, 0, 1 + RD_LAT, slave_data(32'h720)));
    #1;
    reset_n   = 1;
    have_prev = 0;
    wait_drain(200);
    chk("post_rst_owner", 32'(owner), 32'h1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
